fetch_queue: RTL and testbench

//  Producer end of the fetch-group handshake consumed by the decode stage.
//  - Generates sequential block-aligned fetch requests to instruction memory.
//  - Buffers in-order responses as groups of NR_INSTRS tortoise_pkg::fetch_entry_t.
//  - Presents the head group via fetch_valid_o/fetch_pop_i.
//  - On flush, redirects the PC and discards stale in-flight responses.

---
 rtl/fetch_queue.sv | 152 +++++++++++++++
 tb/tb_fetch_queue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch-group producer: issues block-aligned fetch requests, buffers in-order responses as
// groups of NR_INSTRS entries for decode. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned      NR_INSTRS       = 4,
  parameter int unsigned      DEPTH           = 4,
  parameter int unsigned      MAX_OUTSTANDING = 2,
  parameter int unsigned      VLEN            = 64,
  parameter logic [VLEN-1:0]  BOOT_ADDR       = 64'h8000_0000,
  // Entry layout (MSB first): addr, instr, ex_valid, ex_cause[63:0], ex_tval
  localparam int unsigned     ENTRY_W         = 2 * VLEN + 32 + 1 + 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [VLEN-1:0]               flush_pc_i,
  output logic                          req_valid_o,
  input  logic                          req_ready_i,
  output logic [VLEN-1:0]               req_addr_o,
  input  logic                          rsp_valid_i,
  input  logic [NR_INSTRS*32-1:0]       rsp_data_i,
  input  logic                          rsp_err_i,
  output logic                          fetch_valid_o,
  input  logic                          fetch_pop_i,
  output logic [NR_INSTRS*ENTRY_W-1:0]  fetch_o
);

  localparam int unsigned     Blk       = NR_INSTRS * 4;
  localparam int unsigned     GroupW    = NR_INSTRS * ENTRY_W;
  localparam int unsigned     PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW      = $clog2(DEPTH + 1);
  localparam int unsigned     OutW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [VLEN-1:0] BlkInc    = VLEN'(Blk);
  localparam logic [VLEN-1:0] OffMask   = VLEN'(Blk - 1);
  localparam logic [63:0]     InstrAccessFault = 64'd1;

  typedef struct packed {
    logic [VLEN-1:0] addr;
    logic [31:0]     instr;
    logic            ex_valid;
    logic [63:0]     ex_cause;
    logic [VLEN-1:0] ex_tval;
  } entry_t;

  function automatic logic [VLEN-1:0] align(input logic [VLEN-1:0] a);
    return a & ~OffMask;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PtrW'(1);
  endfunction

  logic [VLEN-1:0]   pc_q, pc_d;
  logic [VLEN-1:0]   rsp_pc_q, rsp_pc_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OutW-1:0]   out_q, out_d;
  logic [OutW-1:0]   drop_q, drop_d;
  logic [GroupW-1:0] mem_q [DEPTH];

  logic [GroupW-1:0] rsp_group;
  logic              req_fire;
  logic              rsp_keep;
  logic              bypass;
  logic              push;
  logic              pop;

  // Build the incoming group from the response PC and raw block data.
  for (genvar g = 0; g < int'(NR_INSTRS); g++) begin : g_slot
    entry_t e;
    assign e.addr     = rsp_pc_q + VLEN'(4 * g);
    assign e.instr    = rsp_err_i ? 32'h0 : rsp_data_i[32*g +: 32];
    assign e.ex_valid = rsp_err_i;
    assign e.ex_cause = InstrAccessFault;
    assign e.ex_tval  = e.addr;
    assign rsp_group[g*ENTRY_W +: ENTRY_W] = e;
  end

  // Credit covers both buffered groups and in-flight requests, so a response never overflows.
  assign req_valid_o = !rst_i && !flush_i
                       && (32'(cnt_q) + 32'(out_q) < DEPTH)
                       && (32'(out_q) < MAX_OUTSTANDING);
  assign req_addr_o  = pc_q;
  assign req_fire    = req_valid_o && req_ready_i;
  assign rsp_keep    = rsp_valid_i && (drop_q == '0) && !flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass  = rsp_keep && (cnt_q == '0);
  assign fetch_o = (cnt_q != '0) ? mem_q[rd_ptr_q] : rsp_group;
`else
  assign bypass  = 1'b0;
  assign fetch_o = mem_q[rd_ptr_q];
`endif

  assign fetch_valid_o = !rst_i && ((cnt_q != '0) || bypass);
  assign pop           = !flush_i && fetch_pop_i && (cnt_q != '0);
  // A bypassed group that decode takes immediately never enters the queue.
  assign push          = rsp_keep && !(bypass && fetch_pop_i);

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    drop_d   = drop_q;
    if (flush_i) begin
      pc_d     = align(flush_pc_i);
      rsp_pc_d = align(flush_pc_i);
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      // Everything still in flight after this cycle is stale.
      out_d    = out_q - OutW'(rsp_valid_i);
      drop_d   = out_q - OutW'(rsp_valid_i);
    end else begin
      if (req_fire) pc_d = pc_q + BlkInc;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + BlkInc;
      if (rsp_valid_i && (drop_q != '0)) drop_d = drop_q - OutW'(1);
      out_d = out_q + OutW'(req_fire) - OutW'(rsp_valid_i);
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= align(BOOT_ADDR);
      rsp_pc_q <= align(BOOT_ADDR);
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wr_ptr_q] <= rsp_group;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with default parameters (BLK = 16 bytes, DEPTH 4, 2 in flight).
// Expectations adapt to FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;

  localparam int unsigned NI = 4;
  localparam int unsigned EW = 2 * 64 + 32 + 1 + 64;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i, flush_i, req_valid_o, req_ready_i;
  logic              rsp_valid_i, rsp_err_i, fetch_valid_o, fetch_pop_i;
  logic [63:0]       flush_pc_i, req_addr_o;
  logic [NI*32-1:0]  rsp_data_i;
  logic [NI*EW-1:0]  fetch_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [63:0] inflight [$];
  logic [63:0] err_blk = 64'h8000_0040;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .flush_pc_i    (flush_pc_i),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_addr_o    (req_addr_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_data_i    (rsp_data_i),
    .rsp_err_i     (rsp_err_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_pop_i   (fetch_pop_i),
    .fetch_o       (fetch_o)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_word(input logic [63:0] a);
    return ~a[31:0];
  endfunction

  function automatic logic [NI*32-1:0] mk_data(input logic [63:0] base);
    logic [NI*32-1:0] d;
    for (int i = 0; i < int'(NI); i++) d[32*i +: 32] = mk_word(base + 64'(4 * i));
    return d;
  endfunction

  function automatic logic [255:0] exp_entry(input logic [63:0] a, input logic err);
    logic [EW-1:0] e;
    e = {a, (err ? 32'h0 : mk_word(a)), err, 64'd1, a};
    return 256'(e);
  endfunction

  task automatic check_group(input string tag, input logic [63:0] base, input logic err);
    for (int i = 0; i < int'(NI); i++)
      check(tag, 256'(fetch_o[i*EW +: EW]), exp_entry(base + 64'(4 * i), err));
  endtask

  // Memory model: answers the oldest accepted request when enabled.
  task automatic drive_rsp(input bit en);
    rsp_valid_i = en && (inflight.size() != 0);
    if (rsp_valid_i) begin
      rsp_data_i = mk_data(inflight[0]);
      rsp_err_i  = (inflight[0] == err_blk);
    end else begin
      rsp_data_i = '0;
      rsp_err_i  = 1'b0;
    end
    #1;
  endtask

  task automatic tick();
    logic        fire;
    logic [63:0] a;
    fire = req_valid_o && req_ready_i;
    a    = req_addr_o;
    @(posedge clk);
    if (rsp_valid_i && inflight.size() != 0) void'(inflight.pop_front());
    if (fire) inflight.push_back(a);
    @(negedge clk);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; flush_pc_i = '0; req_ready_i = 1'b0;
    fetch_pop_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = '0; rsp_err_i = 1'b0;
    @(negedge clk);
    drive_rsp(0);
    check("rst_req_valid", req_valid_o, 0);
    check("rst_fetch_valid", fetch_valid_o, 0);
    tick();
    rst_i = 1'b0;

    // Sequential fetch with 1-cycle memory, no pops: fills to exactly DEPTH groups.
    req_ready_i = 1'b1;
    drive_rsp(1);
    check("first_req_valid", req_valid_o, 1);
    check("first_req_addr", req_addr_o, 64'h8000_0000);
    tick();
    drive_rsp(1);
    check("req_addr_1", req_addr_o, 64'h8000_0010);
    check("rsp0_fetch_valid", fetch_valid_o, BYP);
    tick();
    drive_rsp(1);
    check("g0_fetch_valid", fetch_valid_o, 1);
    check_group("g0_slot", 64'h8000_0000, 0);
    check("req_addr_2", req_addr_o, 64'h8000_0020);
    tick();
    drive_rsp(1);
    check("req_addr_3", req_addr_o, 64'h8000_0030);
    check("req_valid_3", req_valid_o, 1);
    tick();
    drive_rsp(1);
    check("credit_stop", req_valid_o, 0);
    tick();
    fetch_pop_i = 1'b1;
    drive_rsp(1);
    check("full_no_req", req_valid_o, 0);
    check("full_fetch_valid", fetch_valid_o, 1);
    check_group("full_head", 64'h8000_0000, 0);
    tick();
    fetch_pop_i = 1'b0;
    drive_rsp(1);
    check("one_new_req_valid", req_valid_o, 1);
    check("one_new_req_addr", req_addr_o, 64'h8000_0040);
    tick();
    drive_rsp(1);
    check("only_one_req", req_valid_o, 0);
    tick();

    // Drain in order; block 0x8000_0040 carries an access fault.
    req_ready_i = 1'b0;
    fetch_pop_i = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      drive_rsp(0);
      check("drain_valid", fetch_valid_o, 1);
      check_group("drain_slot", 64'h8000_0000 + 64'(16 * b), (b == 4));
      tick();
    end
    fetch_pop_i = 1'b0;
    drive_rsp(0);
    check("drained", fetch_valid_o, 0);

    // Flush with two requests in flight.
    req_ready_i = 1'b1;
    check("pre_flush_addr0", req_addr_o, 64'h8000_0050);
    tick();
    drive_rsp(0);
    check("pre_flush_addr1", req_addr_o, 64'h8000_0060);
    tick();
    drive_rsp(0);
    check("max_outstanding", req_valid_o, 0);
    flush_i = 1'b1; flush_pc_i = 64'h8000_1004;
    drive_rsp(0);
    check("flush_no_req", req_valid_o, 0);
    tick();
    flush_i = 1'b0;
    drive_rsp(1);
    check("stale0_dropped", fetch_valid_o, 0);
    check("stale0_no_req", req_valid_o, 0);
    tick();
    drive_rsp(1);
    check("stale1_dropped", fetch_valid_o, 0);
    check("redirect_req_valid", req_valid_o, 1);
    check("redirect_req_addr", req_addr_o, 64'h8000_1000);
    tick();
    req_ready_i = 1'b0;
    drive_rsp(1);
    check("redirect_rsp_bypass", fetch_valid_o, BYP);
    tick();
    drive_rsp(0);
    check("redirect_valid", fetch_valid_o, 1);
    check_group("redirect_slot", 64'h8000_1000, 0);

    // Flush coinciding with a response and a pop.
    req_ready_i = 1'b1;
    drive_rsp(0);
    check("t5_req_addr0", req_addr_o, 64'h8000_1010);
    tick();
    drive_rsp(0);
    check("t5_req_addr1", req_addr_o, 64'h8000_1020);
    tick();
    req_ready_i = 1'b0;
    flush_i = 1'b1; flush_pc_i = 64'h8000_2000; fetch_pop_i = 1'b1;
    drive_rsp(1);
    tick();
    flush_i = 1'b0; fetch_pop_i = 1'b0;
    drive_rsp(0);
    check("flush_empty", fetch_valid_o, 0);
    tick();
    drive_rsp(1);
    check("drop_remaining", fetch_valid_o, 0);
    tick();
    req_ready_i = 1'b1;
    drive_rsp(0);
    check("after_drop_idle", fetch_valid_o, 0);
    check("t5_redirect_valid", req_valid_o, 1);
    check("t5_redirect_addr", req_addr_o, 64'h8000_2000);
    tick();
    req_ready_i = 1'b0;

    // Empty queue, response arrives while decode holds pop.
    fetch_pop_i = 1'b1;
    drive_rsp(1);
    check("byp_same_cycle", fetch_valid_o, BYP);
    if (BYP) check_group("byp_slot", 64'h8000_2000, 0);
    tick();
    drive_rsp(0);
    check("byp_next_cycle", fetch_valid_o, !BYP);
    if (!BYP) check_group("nobyp_slot", 64'h8000_2000, 0);
    tick();
    fetch_pop_i = 1'b0;
    drive_rsp(0);
    check("byp_after", fetch_valid_o, 0);

    // Reset with a group buffered.
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    drive_rsp(1);
    tick();
    drive_rsp(0);
    check("pre_rst_valid", fetch_valid_o, 1);
    rst_i = 1'b1;
    drive_rsp(0);
    check("midrst_fetch_valid", fetch_valid_o, 0);
    check("midrst_req_valid", req_valid_o, 0);
    tick();
    rst_i = 1'b0;
    inflight.delete();
    drive_rsp(0);
    check("postrst_fetch_valid", fetch_valid_o, 0);
    check("postrst_req_valid", req_valid_o, 1);
    check("postrst_req_addr", req_addr_o, 64'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
